stream_req_arbiter: RTL and testbench
=====================================

Name: stream_req_arbiter

Overview:
- Shares the single filter/input stream engine (memory-side streamer) among NUM_PE PE controllers.
- Round-robin arbitration over PE stream requests; issues one command per grant; counts returned beats until last.
- Returns per-PE filter_finish / input_finish pulses, which the PE controllers consume as their stream-complete responses.

Parameters:
- NUM_PE, 4, number of requesting PE controllers (>=2)
- K_W, 6, width of filter index k
- LAYER_W, 3, width of conv layer number
- TIMEOUT, 1023, max idle cycles between beats (used only with optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_filter_valid  in  NUM_PE  per-PE filter stream request, level, held until finish
- req_input_valid  in  NUM_PE  per-PE input stream request, level, held until finish
- req_filter_k  in  NUM_PE*K_W  per-PE filter index; PE i at bits [i*K_W +: K_W]
- req_layer  in  NUM_PE*LAYER_W  per-PE conv layer number, packed as above
- cmd_valid  out  1  stream command valid
- cmd_ready  in  1  streamer accepts command
- cmd_type  out  1  0=filter, 1=input
- cmd_pe  out  $clog2(NUM_PE)  granted PE id
- cmd_k  out  K_W  filter index of granted PE
- cmd_layer  out  LAYER_W  layer of granted PE
- beat_valid  in  1  streamer delivered one beat to granted PE
- beat_last  in  1  qualifies beat_valid; final beat of current command
- filter_finish  out  NUM_PE  one-cycle pulse, filter stream complete for PE i
- input_finish  out  NUM_PE  one-cycle pulse, input stream complete for PE i
- busy  out  1  high in any state but IDLE
- err_timeout  out  1  sticky beat-timeout flag

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, mask=0, all outputs 0, cmd fields 0.
- Requesting PE: req_filter_valid[i] | req_input_valid[i], excluding mask[i].
- States: IDLE, CMD, XFER, DONE.
- IDLE: if any requesting PE, choose the first requesting PE at or after rr_ptr (wrapping modulo NUM_PE). Register its id, k and layer. Type = filter if its filter request is high, else input. Go to CMD; grant decided in one cycle. Otherwise stay in IDLE.
- CMD: cmd_valid=1, fields stable until the cmd_valid & cmd_ready cycle; then go to XFER. Beat count cleared.
- XFER: on beat_valid, increment a 16-bit beat counter (saturating). Beats received while in CMD are ignored.
  - On beat_valid & beat_last, go to DONE.
  - beat_last without beat_valid is ignored.
- DONE (one cycle): pulse filter_finish[pe] or input_finish[pe] per type.
  - If type was filter and req_input_valid[pe] is still high, re-enter CMD with type=input for the same PE (locked grant). Layer-0 PEs therefore get both streams back-to-back.
  - Otherwise set rr_ptr = pe+1 (wrap), set mask to one-hot pe for exactly one cycle, and go to IDLE.
- Mask clears after one IDLE cycle. This prevents re-granting a request the PE has not yet dropped after its registered state update.
- A request dropping while granted does not abort the transfer; the finish pulse is still issued.
- Requests from other PEs during CMD/XFER/DONE wait; no preemption.
- At most one finish bit is high per cycle. filter_finish and input_finish are never both high.
- busy = (state != IDLE).

Optional Feature:
- Macro STREAM_ARB_TIMEOUT_EN.
- Defined:
  - In XFER, an idle counter resets on each beat_valid and increments otherwise.
  - When it reaches TIMEOUT: set err_timeout (sticky until reset), issue the normal finish pulse for the granted PE, and go to DONE.
- Undefined: no counter; err_timeout tied 0; XFER waits indefinitely.

Test Plan:
- Single request: PE2 filter_valid, k=5, layer=1; cmd_ready=1; 3 beats, last on 3rd -> cmd_pe=2, cmd_k=5, cmd_type=0; filter_finish=4'b0100 for one cycle, exactly 1 cycle after the last beat; busy low the following cycle.
- Layer-0 locked grant: PE0 filter_valid and input_valid both held -> filter command, filter_finish[0], then an input command to PE0 without intervening grants to PE1 (also requesting), then input_finish[0].
- Round-robin: PE0, PE1, PE3 request continuously, each transfer 1 beat -> grant order 0,1,3,0,...; mask prevents immediate re-grant of PE0.
- Backpressure: cmd_ready low for 5 cycles -> cmd_valid and fields held stable; beats during CMD ignored; transfer starts only after the handshake.
- Async reset mid-XFER: drop rst between beats -> all outputs 0 immediately, state IDLE; after release, a still-held request is re-granted from rr_ptr=0.
- With STREAM_ARB_TIMEOUT_EN, TIMEOUT=8: grant PE1, no beats -> after 8 idle cycles err_timeout=1 (sticky), filter_finish[1] pulses, next request is served normally.

Source files
------------

// File: rtl/stream_req_arbiter.sv
// Round-robin arbiter sharing one filter/input streamer among NUM_PE PE controllers.
// Optional beat-timeout watchdog enabled by defining STREAM_ARB_TIMEOUT_EN.
module stream_req_arbiter #(
  parameter int unsigned NUM_PE  = 4,
  parameter int unsigned K_W     = 6,
  parameter int unsigned LAYER_W = 3,
  parameter int unsigned TIMEOUT = 1023,
  localparam int unsigned PE_W   = $clog2(NUM_PE)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_PE-1:0]          i_req_filter_valid,
  input  logic [NUM_PE-1:0]          i_req_input_valid,
  input  logic [NUM_PE*K_W-1:0]      i_req_filter_k,
  input  logic [NUM_PE*LAYER_W-1:0]  i_req_layer,
  output logic                       o_cmd_valid,
  input  logic                       i_cmd_ready,
  output logic                       o_cmd_type,
  output logic [PE_W-1:0]            o_cmd_pe,
  output logic [K_W-1:0]             o_cmd_k,
  output logic [LAYER_W-1:0]         o_cmd_layer,
  input  logic                       i_beat_valid,
  input  logic                       i_beat_last,
  output logic [NUM_PE-1:0]          o_filter_finish,
  output logic [NUM_PE-1:0]          o_input_finish,
  output logic                       o_busy,
  output logic                       o_err_timeout
);

  typedef enum logic [1:0] {StIdle, StCmd, StXfer, StDone} state_e;

  state_e               r_state;
  logic [PE_W-1:0]      r_rr_ptr;
  logic [PE_W-1:0]      r_pe;
  logic [NUM_PE-1:0]    r_mask;
  logic                 r_type;
  logic [K_W-1:0]       r_k;
  logic [LAYER_W-1:0]   r_layer;
  logic [15:0]          r_beat_cnt;
  logic                 r_cmd_valid;
  logic [NUM_PE-1:0]    r_filter_finish;
  logic [NUM_PE-1:0]    r_input_finish;
  logic                 r_err_timeout;

  logic [NUM_PE-1:0]    w_req;
  logic                 w_gnt_found;
  logic [PE_W-1:0]      w_gnt_pe;
  logic [K_W-1:0]       w_gnt_k;
  logic [LAYER_W-1:0]   w_gnt_layer;
  logic                 w_gnt_filter;
  int unsigned          w_idx;
  logic [PE_W-1:0]      w_pe_next;
  logic [NUM_PE-1:0]    w_fin_onehot;

`ifdef STREAM_ARB_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0]    r_idle_cnt;
`endif

  // The just-served PE is masked for one IDLE cycle while it drops its request
  assign w_req = (i_req_filter_valid | i_req_input_valid) & ~r_mask;

  always_comb begin
    w_gnt_found  = 1'b0;
    w_gnt_pe     = '0;
    w_gnt_k      = '0;
    w_gnt_layer  = '0;
    w_gnt_filter = 1'b0;
    w_idx        = 0;
    for (int unsigned off = 0; off < NUM_PE; off++) begin
      w_idx = (32'(r_rr_ptr) + off) % NUM_PE;
      if (!w_gnt_found && w_req[w_idx]) begin
        w_gnt_found  = 1'b1;
        w_gnt_pe     = PE_W'(w_idx);
        w_gnt_k      = i_req_filter_k[w_idx*K_W +: K_W];
        w_gnt_layer  = i_req_layer[w_idx*LAYER_W +: LAYER_W];
        w_gnt_filter = i_req_filter_valid[w_idx];
      end
    end
  end

  assign w_pe_next    = (r_pe == PE_W'(NUM_PE - 1)) ? '0 : r_pe + 1'b1;
  assign w_fin_onehot = NUM_PE'(1) << r_pe;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= StIdle;
      r_rr_ptr        <= '0;
      r_pe            <= '0;
      r_mask          <= '0;
      r_type          <= 1'b0;
      r_k             <= '0;
      r_layer         <= '0;
      r_beat_cnt      <= '0;
      r_cmd_valid     <= 1'b0;
      r_filter_finish <= '0;
      r_input_finish  <= '0;
      r_err_timeout   <= 1'b0;
`ifdef STREAM_ARB_TIMEOUT_EN
      r_idle_cnt      <= '0;
`endif
    end else begin
      r_mask          <= '0;
      r_filter_finish <= '0;
      r_input_finish  <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_gnt_found) begin
            r_pe        <= w_gnt_pe;
            r_k         <= w_gnt_k;
            r_layer     <= w_gnt_layer;
            r_type      <= ~w_gnt_filter;
            r_cmd_valid <= 1'b1;
            r_state     <= StCmd;
          end
        end
        StCmd: begin
          if (i_cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_beat_cnt  <= '0;
`ifdef STREAM_ARB_TIMEOUT_EN
            r_idle_cnt  <= '0;
`endif
            r_state     <= StXfer;
          end
        end
        StXfer: begin
          if (i_beat_valid) begin
            if (r_beat_cnt != 16'hffff) r_beat_cnt <= r_beat_cnt + 16'd1;
`ifdef STREAM_ARB_TIMEOUT_EN
            r_idle_cnt <= '0;
`endif
            if (i_beat_last) begin
              if (r_type) r_input_finish  <= w_fin_onehot;
              else        r_filter_finish <= w_fin_onehot;
              r_state <= StDone;
            end
          end
`ifdef STREAM_ARB_TIMEOUT_EN
          else if (r_idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
            r_err_timeout <= 1'b1;
            if (r_type) r_input_finish  <= w_fin_onehot;
            else        r_filter_finish <= w_fin_onehot;
            r_state <= StDone;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
`endif
        end
        StDone: begin
          // Filter done with input still pending: keep the grant for the input stream
          if (!r_type && i_req_input_valid[r_pe]) begin
            r_type      <= 1'b1;
            r_cmd_valid <= 1'b1;
            r_state     <= StCmd;
          end else begin
            r_rr_ptr <= w_pe_next;
            r_mask   <= w_fin_onehot;
            r_state  <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_cmd_valid     = r_cmd_valid;
  assign o_cmd_type      = r_type;
  assign o_cmd_pe        = r_pe;
  assign o_cmd_k         = r_k;
  assign o_cmd_layer     = r_layer;
  assign o_filter_finish = r_filter_finish;
  assign o_input_finish  = r_input_finish;
  assign o_busy          = (r_state != StIdle);
  assign o_err_timeout   = r_err_timeout;

endmodule

// File: tb/tb_stream_req_arbiter.sv
// Scoreboard bench for stream_req_arbiter: directed requests, expected commands/finishes queued.
module tb_stream_req_arbiter;

  typedef struct packed {
    logic       typ;
    logic [1:0] pe;
    logic [5:0] k;
    logic [2:0] layer;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_f, req_i;
  logic [23:0] req_k;
  logic [11:0] req_l;
  logic        cmd_ready, beat_valid, beat_last;
  logic        cmd_valid, cmd_type, busy, err_timeout;
  logic [1:0]  cmd_pe;
  logic [5:0]  cmd_k;
  logic [2:0]  cmd_layer;
  logic [3:0]  filter_finish, input_finish;

  int n_checks = 0;
  int n_fail   = 0;

  cmd_t       exp_cmd_q[$];
  logic [7:0] exp_fin_q[$];

  always #5 clk = ~clk;

  stream_req_arbiter #(
    .NUM_PE (4),
    .K_W    (6),
    .LAYER_W(3),
    .TIMEOUT(8)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_req_filter_valid(req_f),
    .i_req_input_valid (req_i),
    .i_req_filter_k    (req_k),
    .i_req_layer       (req_l),
    .o_cmd_valid       (cmd_valid),
    .i_cmd_ready       (cmd_ready),
    .o_cmd_type        (cmd_type),
    .o_cmd_pe          (cmd_pe),
    .o_cmd_k           (cmd_k),
    .o_cmd_layer       (cmd_layer),
    .i_beat_valid      (beat_valid),
    .i_beat_last       (beat_last),
    .o_filter_finish   (filter_finish),
    .o_input_finish    (input_finish),
    .o_busy            (busy),
    .o_err_timeout     (err_timeout)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic cmd_t mk(input logic t, input logic [1:0] pe, input logic [5:0] k,
                              input logic [2:0] l);
    cmd_t c;
    c.typ = t; c.pe = pe; c.k = k; c.layer = l;
    return c;
  endfunction

  // Packed as {input_finish, filter_finish}
  function automatic logic [7:0] fin(input logic t, input int pe);
    return 8'(1) << (pe + (t ? 4 : 0));
  endfunction

  // Monitor: pops expectations whenever the DUT hands over a command or a finish
  always @(negedge clk) begin
    cmd_t       ec;
    logic [7:0] ef;
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL cmd_unexpected: got pe=%0d type=%0d, none expected", cmd_pe, cmd_type);
        end else begin
          ec = exp_cmd_q.pop_front();
          check("cmd_fields", 32'({cmd_type, cmd_pe, cmd_k, cmd_layer}), 32'(ec));
        end
      end
      if ((filter_finish | input_finish) != 4'b0) begin
        check("finish_onehot", $countones({input_finish, filter_finish}), 1);
        if (exp_fin_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL finish_unexpected: got %0h, none expected", {input_finish, filter_finish});
        end else begin
          ef = exp_fin_q.pop_front();
          check("finish_vec", 32'({input_finish, filter_finish}), 32'(ef));
        end
      end
    end
  end

  task automatic wait_cmd(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = cmd_valid;
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL wait_cmd: cmd_valid=0 required 1 within 50 cycles");
    end
  endtask

  // Accept one command (after optional backpressure) and deliver nbeats beats.
  // Returns at posedge+1 of the cycle in which the arbiter sits in DONE.
  task automatic serve(input int nbeats, input int hold, input bit stray);
    bit   seen;
    cmd_t snap;
    wait_cmd(seen);
    if (!seen) return;
    if (hold > 0) begin
      snap = {cmd_type, cmd_pe, cmd_k, cmd_layer};
      @(posedge clk); #1;
      beat_valid = 1'b1; beat_last = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("bp_valid", 32'(cmd_valid), 32'd1);
        check("bp_fields", 32'({cmd_type, cmd_pe, cmd_k, cmd_layer}), 32'(snap));
        @(posedge clk); #1;
      end
      beat_valid = 1'b0; beat_last = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    if (stray) begin
      beat_valid = 1'b0; beat_last = 1'b1;
      @(posedge clk); #1;
    end
    for (int b = 0; b < nbeats; b++) begin
      beat_valid = 1'b1;
      beat_last  = (b == nbeats - 1);
      @(posedge clk); #1;
    end
    beat_valid = 1'b0; beat_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen;
    cmd_ready = 0; beat_valid = 0; beat_last = 0;
    req_f = '0; req_i = '0;
    req_k = {6'd63, 6'd5, 6'd2, 6'd1};
    req_l = {3'd7, 3'd1, 3'd2, 3'd0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_fields", 32'({cmd_type, cmd_pe, cmd_k, cmd_layer}), 0);
    check("rst_finish", 32'({input_finish, filter_finish, err_timeout}), 0);
    @(negedge clk) rst_n = 1'b1;

    // Round robin over PE0, PE1, PE3 from rr_ptr = 0
    req_f = 4'b1011;
    for (int r = 0; r < 2; r++) begin
      exp_cmd_q.push_back(mk(0, 0, 1, 0));  exp_fin_q.push_back(fin(0, 0));
      exp_cmd_q.push_back(mk(0, 1, 2, 2));  exp_fin_q.push_back(fin(0, 1));
      exp_cmd_q.push_back(mk(0, 3, 63, 7)); exp_fin_q.push_back(fin(0, 3));
    end
    for (int t = 0; t < 6; t++) serve(1, 0, 0);
    @(posedge clk); #1 req_f = '0;

    // Single PE2 request, stray beat_last, request held through the masked cycle
    req_f = 4'b0100;
    exp_cmd_q.push_back(mk(0, 2, 5, 1)); exp_fin_q.push_back(fin(0, 2));
    serve(3, 0, 1);
    @(negedge clk);
    check("t1_finish_after_last", 32'(filter_finish), 32'b0100);
    check("t1_busy_done", 32'(busy), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_busy_idle", 32'(busy), 0);
    check("t1_no_regrant", 32'({cmd_valid, filter_finish}), 0);
    @(posedge clk); #1 req_f = '0;
    @(negedge clk);
    check("t1_still_idle", 32'(busy), 0);

    // Layer-0 locked grant: PE0 filter then input, PE1 waits
    req_f = 4'b0011; req_i = 4'b0001;
    exp_cmd_q.push_back(mk(0, 0, 1, 0)); exp_fin_q.push_back(fin(0, 0));
    exp_cmd_q.push_back(mk(1, 0, 1, 0)); exp_fin_q.push_back(fin(1, 0));
    exp_cmd_q.push_back(mk(0, 1, 2, 2)); exp_fin_q.push_back(fin(0, 1));
    serve(2, 0, 0);
    @(posedge clk); #1 req_f[0] = 1'b0;
    serve(1, 0, 0);
    @(posedge clk); #1 req_i[0] = 1'b0;
    serve(1, 0, 0);
    @(posedge clk); #1 req_f[1] = 1'b0;

    // Backpressure on PE3 with beats during CMD that must be ignored
    req_f = 4'b1000;
    exp_cmd_q.push_back(mk(0, 3, 63, 7)); exp_fin_q.push_back(fin(0, 3));
    serve(2, 5, 0);
    @(posedge clk); #1 req_f = '0;

    // Async reset mid-transfer, rr_ptr restarts at 0
    req_f = 4'b0010;
    exp_cmd_q.push_back(mk(0, 1, 2, 2)); exp_fin_q.push_back(fin(0, 1));
    serve(1, 0, 0);
    @(posedge clk); #1;
    req_f = 4'b1000; req_i = 4'b0010;
    exp_cmd_q.push_back(mk(0, 3, 63, 7));
    wait_cmd(seen);
    @(posedge clk); #1 cmd_ready = 1'b1;
    @(posedge clk); #1 cmd_ready = 1'b0; beat_valid = 1'b1;
    @(posedge clk); #1 beat_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_cmd", 32'({cmd_valid, cmd_type, cmd_pe, cmd_k, cmd_layer}), 0);
    check("arst_finish", 32'({input_finish, filter_finish, err_timeout}), 0);
    exp_cmd_q.push_back(mk(1, 1, 2, 2)); exp_fin_q.push_back(fin(1, 1));
    exp_cmd_q.push_back(mk(0, 3, 63, 7)); exp_fin_q.push_back(fin(0, 3));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    serve(1, 0, 0);
    @(posedge clk); #1 req_i = '0;
    serve(1, 0, 0);
    @(posedge clk); #1 req_f = '0;

`ifdef STREAM_ARB_TIMEOUT_EN
    // Timeout: PE1 granted, no beats ever arrive
    req_f = 4'b0010;
    exp_cmd_q.push_back(mk(0, 1, 2, 2)); exp_fin_q.push_back(fin(0, 1));
    wait_cmd(seen);
    @(posedge clk); #1 cmd_ready = 1'b1;
    @(posedge clk); #1 cmd_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      seen = !busy;
    end
    check("to_returned_idle", 32'(seen), 1);
    check("to_err_set", 32'(err_timeout), 1);
    @(posedge clk); #1 req_f = '0;
    req_f = 4'b0100;
    exp_cmd_q.push_back(mk(0, 2, 5, 1)); exp_fin_q.push_back(fin(0, 2));
    serve(1, 0, 0);
    @(posedge clk); #1 req_f = '0;
    check("to_err_sticky", 32'(err_timeout), 1);
`else
    check("no_timeout_err", 32'(err_timeout), 0);
`endif

    repeat (5) @(posedge clk);
    check("cmd_queue_drained", exp_cmd_q.size(), 0);
    check("fin_queue_drained", exp_fin_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
